sram_stream_fifo: RTL
=====================

# sram_stream_fifo

SRAM-backed stream FIFO with valid/ready handshakes on both sides. It stores up to `NumWords` words in a single-port, latency-1 `tc_sram` plus a 2-entry output prefetch buffer. Read data is registered, so `out_data_o` never comes straight from the macro. It replaces bare shift-register buffering in the SD data path with:
- back-pressure on both sides,
- fill-level reporting,
- synchronous flush,
- non-power-of-two depth.

## Interface
- `NumWords`, 1024: SRAM depth, any value ≥ 2 (non-power-of-two allowed).
- `DataWidth`, 32: word width in bits.
- `AddrWidth`, `cf_math_pkg::idx_width(NumWords)`: SRAM address width.
- `LevelWidth`, `cf_math_pkg::idx_width(NumWords + 3)`: width of `level_o`.

Ports:
- `clk_i`  in  1  clock; all logic is on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `flush_i`  in  1  synchronous clear of all contents.
- `in_valid_i`  in  1  producer has a word.
- `in_ready_o`  out  1  FIFO accepts the word this cycle.
- `in_data_i`  in  DataWidth  pushed word.
- `out_valid_o`  out  1  `out_data_o` holds the oldest word.
- `out_ready_i`  in  1  consumer takes the word.
- `out_data_o`  out  DataWidth  head word, driven from a register.
- `level_o`  out  LevelWidth  count of accepted words not yet popped.
- `full_o`  out  1  SRAM holds `NumWords` words.
- `empty_o`  out  1  `level_o == 0`.

## Operation
- **Handshakes:** push = `in_valid_i & in_ready_o`; pop = `out_valid_o & out_ready_i`.
- **Valid stability:** once `out_valid_o` is asserted, it and `out_data_o` stay stable until popped.
- **State:** `wr_ptr`, `rd_ptr` (wrap from `NumWords-1` to 0), `sram_cnt`, `rd_inflight` (0/1), `buf_cnt` (0..2).
- **Level:** `level_o = sram_cnt + rd_inflight + buf_cnt`; total capacity is `NumWords + 2`.
- **Read request:** `rd_want = sram_cnt > 0 && (buf_cnt + rd_inflight - pop) < 2`.
- **Starve condition:** `starve = sram_cnt > 0 && buf_cnt + rd_inflight == 0`, computed from registers only.
- **Port arbitration:** one SRAM access per cycle.
  - Reads win when `starve` is true.
  - Otherwise writes win.
  - A read is issued only if `rd_want` holds and no write takes the port.
- **Ready:** `in_ready_o = !rst_i && !flush_i && !starve && (!full_o || bypass_ok)`.
  - `in_ready_o` never depends combinationally on `out_ready_i`.
- **Read return:** read data returns the cycle after the request and is captured into the buffer tail at that cycle's end.
  - `rd_inflight` clears at that capture.
- **Simultaneous push and pop:** both complete. Level is unchanged, apart from a concurrent read return, which only moves words between stages.
- **Flush:**
  - Pointers, counters, buffer and `rd_inflight` clear.
  - A pending SRAM read result is discarded.
  - Push is blocked (`in_ready_o = 0`); a concurrent pop does not complete.
- **Reset:** asynchronous assertion clears state identically to flush.
- **Width rule:** pointer increment uses explicit compare-and-wrap, not modulo on `AddrWidth` overflow.

## Timing
- **Reset values:**
  - `in_ready_o = 0` while `rst_i` is high.
  - `out_valid_o = 0`, `level_o = 0`, `full_o = 0`, `empty_o = 1`.
  - `out_data_o = '0`.
- **Latency without bypass:** a push at edge N writes the SRAM. The read is issued in cycle N+1, data is captured at edge N+2, and `out_valid_o` is high in cycle N+3.
- **Latency with bypass:** push at edge N gives `out_valid_o` in cycle N+1 (see Configuration).
- **Read throughput:** 1 word/cycle when no pushes compete.
- **Combined throughput:** combined push+pop through the SRAM is 1 access/cycle.
- **Starvation bound:** reads preempt writes for at most 1 cycle per starvation event.
- **Full:** `full_o` rises the cycle after the `NumWords`-th SRAM write. `in_ready_o` falls in that same cycle unless the bypass path is open.
- **Empty:** `empty_o` rises the cycle after the last pop.

## Configuration
- **Macro:** `SRAM_FIFO_BYPASS_EN`.
- **Defined:**
  - `bypass_ok = sram_cnt == 0 && rd_inflight == 0 && buf_cnt < 2`, all registered.
  - When `bypass_ok` holds, a push is written directly into the buffer tail and skips the SRAM.
  - First-word latency is 1 cycle.
- **Undefined:** `bypass_ok = 0`. Every word passes through the SRAM, so first-word latency is 3 cycles.

## Test plan
- **First-word latency:** reset, push 0xA5A5_0001 with `out_ready_i = 0` → `out_valid_o` in cycle 3 (cycle 1 with bypass); `level_o = 1`; data matches.
- **Fill and overflow:** push `NumWords + 2` words with the consumer stalled → `in_ready_o` falls after the last accepted word; `level_o = NumWords + 2`; `full_o = 1`; no data is lost.
- **Pointer wrap:** `NumWords = 5`, stream 23 sequential words with random `out_ready_i` → output is an in-order 0..22 sequence, with no duplicates or drops across wrap.
- **Concurrent traffic:** FIFO at level 4, push and pop every cycle for 50 cycles → level stays 4 ± 1; starvation never exceeds 1 blocked push cycle per event.
- **Flush with pending read:** flush while `rd_inflight = 1` → next cycle `level_o = 0`, `out_valid_o = 0`; the stale SRAM word never appears at the output.
- **Reset mid-stream:** assert `rst_i` mid-stream, asynchronously between edges → outputs reach reset values immediately; the first post-reset push behaves as in the first-word latency scenario.

Source files
------------

// File: rtl/sram_stream_fifo_if.sv
// Stream bundle for sram_stream_fifo: push side, pop side, flush and fill status.
// A word moves on a side only in a cycle where its valid and ready are both high at the clock edge.
interface sram_stream_fifo_if #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned LevelWidth = $clog2(NumWords + 3);

  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DataWidth-1:0]  in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DataWidth-1:0]  out_data_o;
  logic [LevelWidth-1:0] level_o;
  logic                  full_o;
  logic                  empty_o;

  modport slave (
    input  flush_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, level_o, full_o, empty_o
  );

  modport master (
    output flush_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, level_o, full_o, empty_o
  );
endinterface

// File: rtl/sram_stream_fifo.sv
// SRAM-backed stream FIFO: single-port latency-1 array plus a 2-entry registered output buffer.
// Define SRAM_FIFO_BYPASS_EN to let pushes into an otherwise empty FIFO skip the SRAM.
module sram_stream_fifo #(
  parameter int unsigned NumWords   = 1024,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned LevelWidth = $clog2(NumWords + 3)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sram_stream_fifo_if.slave bus
);
  localparam int unsigned CntWidth = $clog2(NumWords + 1);

  logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]  sram_cnt_q, sram_cnt_d;
  logic                 rd_inflight_q;
  logic [1:0]           buf_cnt_q, buf_cnt_d;
  logic [DataWidth-1:0] buf_q [2];
  logic [DataWidth-1:0] buf_d [2];
  logic [DataWidth-1:0] mem [NumWords];
  logic [DataWidth-1:0] rd_data_q;

  logic full, starve, bypass_ok, in_ready, push, out_valid, pop;
  logic sram_wr, rd_want, rd_en;
  logic [2:0] occ;

  function automatic logic [AddrWidth-1:0] next_ptr(input logic [AddrWidth-1:0] p);
    return (p == AddrWidth'(NumWords - 1)) ? '0 : p + AddrWidth'(1);
  endfunction

  assign full   = (sram_cnt_q == CntWidth'(NumWords));
  // Head empty with words stuck in the SRAM: the read must win the port now.
  assign starve = (sram_cnt_q != '0) && (buf_cnt_q == 2'd0) && !rd_inflight_q;

`ifdef SRAM_FIFO_BYPASS_EN
  assign bypass_ok = (sram_cnt_q == '0) && !rd_inflight_q && (buf_cnt_q != 2'd2);
`else
  assign bypass_ok = 1'b0;
`endif

  assign in_ready  = !rst_i && !bus.flush_i && !starve && (!full || bypass_ok);
  assign push      = bus.in_valid_i && in_ready;
  assign out_valid = (buf_cnt_q != 2'd0);
  assign pop       = out_valid && bus.out_ready_i && !bus.flush_i;
  assign sram_wr   = push && !bypass_ok;

  // Buffer slots that will be taken once this cycle's pop retires.
  assign occ     = {1'b0, buf_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
  assign rd_want = (sram_cnt_q != '0) && (occ < 3'd2);
  assign rd_en   = rd_want && !sram_wr && !bus.flush_i;

  always_comb begin
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    if (pop) begin
      buf_d[0]  = buf_q[1];
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (rd_inflight_q) begin
      buf_d[buf_cnt_d[0]] = rd_data_q;
      buf_cnt_d           = buf_cnt_d + 2'd1;
    end else if (push && bypass_ok) begin
      buf_d[buf_cnt_d[0]] = bus.in_data_i;
      buf_cnt_d           = buf_cnt_d + 2'd1;
    end
  end

  always_comb begin
    sram_cnt_d = sram_cnt_q;
    if (sram_wr && !rd_en) begin
      sram_cnt_d = sram_cnt_q + CntWidth'(1);
    end else if (rd_en && !sram_wr) begin
      sram_cnt_d = sram_cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sram_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
      buf_cnt_q     <= 2'd0;
      buf_q[0]      <= '0;
      buf_q[1]      <= '0;
    end else if (bus.flush_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sram_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
      buf_cnt_q     <= 2'd0;
      buf_q[0]      <= '0;
      buf_q[1]      <= '0;
    end else begin
      if (sram_wr) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (rd_en)   rd_ptr_q <= next_ptr(rd_ptr_q);
      sram_cnt_q    <= sram_cnt_d;
      rd_inflight_q <= rd_en;
      buf_cnt_q     <= buf_cnt_d;
      buf_q         <= buf_d;
    end
  end

  // Storage array: one access per cycle, read data registered.
  always_ff @(posedge clk_i) begin
    if (sram_wr) mem[wr_ptr_q] <= bus.in_data_i;
    if (rd_en)   rd_data_q <= mem[rd_ptr_q];
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = buf_q[0];
  assign bus.level_o     = LevelWidth'(sram_cnt_q) + LevelWidth'(rd_inflight_q) + LevelWidth'(buf_cnt_q);
  assign bus.full_o      = full;
  assign bus.empty_o     = (sram_cnt_q == '0) && !rd_inflight_q && (buf_cnt_q == 2'd0);
endmodule
